// File: rtl/watchdog_pkg.sv
// ---------------------------------------------------------------------------
// watchdog_pkg
// Shared definitions for the watchdog reset controller:
//   - wdt_state_e : 3-bit controller state, encoding visible on state_o
//   - DEF_*       : default parameter values for the controller
//   - periph_held / core_held : which states keep each reset domain asserted
// ---------------------------------------------------------------------------
package watchdog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARMED      = 3'd1,
        ST_HOLD       = 3'd2,
        ST_REL_PERIPH = 3'd3,
        ST_REL_CORE   = 3'd4,
        ST_GRACE      = 3'd5,
        ST_LOCKOUT    = 3'd6
    } wdt_state_e;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_PERIPH_DELAY = 16;
    localparam int DEF_CORE_DELAY   = 16;
    localparam int DEF_GRACE_CYCLES = 1024;
    localparam int DEF_MAX_RESETS   = 3;
    localparam int DEF_DLY_W        = 16;
    localparam int DEF_RC_W         = 4;

    // Peripherals stay in reset until the REL_PERIPH delay has run out.
    function automatic logic periph_held(input wdt_state_e s);
        return (s == ST_HOLD) || (s == ST_REL_PERIPH) || (s == ST_LOCKOUT);
    endfunction

    // Cores are released one stage later than peripherals.
    function automatic logic core_held(input wdt_state_e s);
        return (s == ST_HOLD) || (s == ST_REL_PERIPH) ||
               (s == ST_REL_CORE) || (s == ST_LOCKOUT);
    endfunction

endpackage

// File: rtl/watchdog_reset_ctrl_hb_collector.sv
// ---------------------------------------------------------------------------
// hb_collector
// Collects heartbeats from N_REQ requesters within one watchdog window and
// issues a single-cycle kick once every enabled requester has checked in.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   i_track       : controller stays in ARMED this cycle (collect heartbeats)
//   i_start       : controller enters ARMED this cycle (fresh window)
//   i_req_mask    : per-requester enable
//   i_hb          : heartbeat pulses
//   o_kick        : registered 1-cycle kick pulse
//   o_missing     : registered set of enabled requesters not yet seen
// ---------------------------------------------------------------------------
module hb_collector
    import watchdog_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_track,
    input  logic             i_start,
    input  logic [N_REQ-1:0] i_req_mask,
    input  logic [N_REQ-1:0] i_hb,
    output logic             o_kick,
    output logic [N_REQ-1:0] o_missing
);

    logic [N_REQ-1:0] r_seen;
    logic [N_REQ-1:0] r_missing;
    logic             r_kick;

    logic [N_REQ-1:0] w_seen_n;
    logic             w_all_seen;
    logic [N_REQ-1:0] w_seen_next;
    logic [N_REQ-1:0] w_missing_next;
    logic             w_kick_next;

    assign w_seen_n   = r_seen | (i_hb & i_req_mask);
    // Masked-off requesters count as present; an empty mask never kicks.
    assign w_all_seen = (i_req_mask != '0) && ((w_seen_n | ~i_req_mask) == '1);

    // Heartbeats arriving in the kicking cycle belong to the window being
    // closed, so the seen vector restarts from zero after a kick.
    always_comb begin
        w_seen_next    = '0;
        w_missing_next = '0;
        w_kick_next    = 1'b0;
        if (i_track) begin
            w_missing_next = i_req_mask & ~w_seen_n;
            if (w_all_seen) begin
                w_kick_next = 1'b1;
            end else begin
                w_seen_next = w_seen_n & i_req_mask;
            end
        end else if (i_start) begin
            w_missing_next = i_req_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_seen    <= '0;
            r_missing <= '0;
            r_kick    <= 1'b0;
        end else begin
            r_seen    <= w_seen_next;
            r_missing <= w_missing_next;
            r_kick    <= w_kick_next;
        end
    end

    assign o_kick    = r_kick;
    assign o_missing = r_missing;

endmodule

// File: rtl/watchdog_reset_ctrl.sv
// ---------------------------------------------------------------------------
// watchdog_reset_ctrl
// Arms the system watchdog timer, kicks it when every enabled requester has
// sent a heartbeat, and on a watchdog fire sequences a staged reset release
// (peripherals, then cores, then a grace window). After MAX_RESETS fires the
// system is locked in reset until rstn.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   arm_i         : supervision enable (level)
//   req_mask_i    : per-requester enable
//   hb_i          : heartbeat pulses
//   wdt_reset_i   : reset output of the watchdog timer
//   wdt_start_o   : timer count-enable
//   wdt_kick_o    : timer clear, 1-cycle pulse
//   periph_rst_o  : active-high peripheral reset
//   core_rst_o    : active-high core reset
//   missing_o     : enabled requesters not yet seen in this window
//   reset_count_o : saturating count of watchdog resets
//   lockout_o     : high while locked out
//   state_o       : controller state for debug
// All outputs are registered.
// ---------------------------------------------------------------------------
module watchdog_reset_ctrl
    import watchdog_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int PERIPH_DELAY = DEF_PERIPH_DELAY,
    parameter int CORE_DELAY   = DEF_CORE_DELAY,
    parameter int GRACE_CYCLES = DEF_GRACE_CYCLES,
    parameter int MAX_RESETS   = DEF_MAX_RESETS,
    parameter int DLY_W        = DEF_DLY_W,
    parameter int RC_W         = DEF_RC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             arm_i,
    input  logic [N_REQ-1:0] req_mask_i,
    input  logic [N_REQ-1:0] hb_i,
    input  logic             wdt_reset_i,
    output logic             wdt_start_o,
    output logic             wdt_kick_o,
    output logic             periph_rst_o,
    output logic             core_rst_o,
    output logic [N_REQ-1:0] missing_o,
    output logic [RC_W-1:0]  reset_count_o,
    output logic             lockout_o,
    output logic [2:0]       state_o
);

    wdt_state_e       r_state;
    logic [DLY_W-1:0] r_dly;
    logic [RC_W-1:0]  r_count;
    logic             r_start;
    logic             r_periph;
    logic             r_core;
    logic             r_lockout;

    wdt_state_e       w_state_next;
    logic [DLY_W-1:0] w_dly_next;
    logic [RC_W-1:0]  w_count_next;
    logic [RC_W-1:0]  w_count_inc;
    logic             w_mask_any;
    logic             w_dly_done;
    logic             w_track;
    logic             w_start_win;

    assign w_mask_any  = |req_mask_i;
    assign w_dly_done  = (r_dly <= DLY_W'(1));
    assign w_count_inc = (r_count == '1) ? r_count : r_count + RC_W'(1);

    // Next-state logic. The shared delay counter is loaded on entry to each
    // release/grace stage and the stage ends when it reaches 1, so every stage
    // lasts exactly its configured number of cycles.
    always_comb begin
        w_state_next = r_state;
        w_dly_next   = r_dly;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (arm_i) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A fire outranks both the kick and disarming.
                if (wdt_reset_i) begin
                    w_count_next = w_count_inc;
                    if (int'(w_count_inc) >= MAX_RESETS) begin
                        w_state_next = ST_LOCKOUT;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end else if (!arm_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!wdt_reset_i) begin
                    w_state_next = ST_REL_PERIPH;
                    w_dly_next   = DLY_W'(PERIPH_DELAY);
                end
            end
            ST_REL_PERIPH: begin
                if (w_dly_done) begin
                    w_state_next = ST_REL_CORE;
                    w_dly_next   = DLY_W'(CORE_DELAY);
                end else begin
                    w_dly_next = r_dly - DLY_W'(1);
                end
            end
            ST_REL_CORE: begin
                if (w_dly_done) begin
                    w_state_next = ST_GRACE;
                    w_dly_next   = DLY_W'(GRACE_CYCLES);
                end else begin
                    w_dly_next = r_dly - DLY_W'(1);
                end
            end
            ST_GRACE: begin
                if (w_dly_done) begin
                    w_state_next = arm_i ? ST_ARMED : ST_IDLE;
                    w_dly_next   = '0;
                end else begin
                    w_dly_next = r_dly - DLY_W'(1);
                end
            end
            ST_LOCKOUT: begin
                w_state_next = ST_LOCKOUT;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_dly_next   = '0;
            end
        endcase
    end

    // Heartbeats are only collected while the controller remains armed; a
    // fresh window opens whenever ARMED is entered from any other state.
    assign w_track     = (r_state == ST_ARMED) && (w_state_next == ST_ARMED);
    assign w_start_win = (r_state != ST_ARMED) && (w_state_next == ST_ARMED);

    hb_collector #(
        .N_REQ (N_REQ)
    ) u_hb_collector (
        .clk        (clk),
        .rstn       (rstn),
        .i_track    (w_track),
        .i_start    (w_start_win),
        .i_req_mask (req_mask_i),
        .i_hb       (hb_i),
        .o_kick     (wdt_kick_o),
        .o_missing  (missing_o)
    );

    // Outputs are registered from the next state so they line up with
    // state_o on the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_dly     <= '0;
            r_count   <= '0;
            r_start   <= 1'b0;
            r_periph  <= 1'b0;
            r_core    <= 1'b0;
            r_lockout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dly     <= w_dly_next;
            r_count   <= w_count_next;
            r_start   <= (w_state_next == ST_ARMED) && w_mask_any;
            r_periph  <= periph_held(w_state_next);
            r_core    <= core_held(w_state_next);
            r_lockout <= (w_state_next == ST_LOCKOUT);
        end
    end

    assign wdt_start_o   = r_start;
    assign periph_rst_o  = r_periph;
    assign core_rst_o    = r_core;
    assign lockout_o     = r_lockout;
    assign reset_count_o = r_count;
    assign state_o       = r_state;

endmodule

// File: tb/tb_watchdog_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_watchdog_reset_ctrl
// Directed bench for watchdog_reset_ctrl. A behavioural model tracks the
// controller at the level of "phase + release timestamp" and a compare
// process checks every DUT output against it on each falling edge. The
// stimulus process adds hand-computed literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_watchdog_reset_ctrl;

    localparam int NR   = 4;
    localparam int PD   = 4;
    localparam int CD   = 4;
    localparam int GR   = 8;
    localparam int MAXR = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_SEQ   = 3;
    localparam int PH_LOCK  = 4;

    logic          clk;
    logic          rstn;
    logic          arm;
    logic [NR-1:0] mask;
    logic [NR-1:0] hb;
    logic          wdtReset;

    logic          wdt_start_o;
    logic          wdt_kick_o;
    logic          periph_rst_o;
    logic          core_rst_o;
    logic [NR-1:0] missing_o;
    logic [3:0]    reset_count_o;
    logic          lockout_o;
    logic [2:0]    state_o;

    int vectors     = 0;
    int miscompares = 0;

    watchdog_reset_ctrl #(
        .N_REQ        (NR),
        .PERIPH_DELAY (PD),
        .CORE_DELAY   (CD),
        .GRACE_CYCLES (GR),
        .MAX_RESETS   (MAXR),
        .DLY_W        (16),
        .RC_W         (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .arm_i         (arm),
        .req_mask_i    (mask),
        .hb_i          (hb),
        .wdt_reset_i   (wdtReset),
        .wdt_start_o   (wdt_start_o),
        .wdt_kick_o    (wdt_kick_o),
        .periph_rst_o  (periph_rst_o),
        .core_rst_o    (core_rst_o),
        .missing_o     (missing_o),
        .reset_count_o (reset_count_o),
        .lockout_o     (lockout_o),
        .state_o       (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; the task returns one cycle later so
    // outputs then reflect the rising edge that consumed these inputs.
    task automatic applyStimulus(input logic rstnV, input logic armV,
                                 input logic [NR-1:0] maskV, input logic [NR-1:0] hbV,
                                 input logic wdtV);
        rstn     = rstnV;
        arm      = armV;
        mask     = maskV;
        hb       = hbV;
        wdtReset = wdtV;
        @(negedge clk);
    endtask

    // Behavioural model: phase plus the cycle index at which the staged
    // release began; release/grace outputs follow from elapsed cycles.
    int            cyc       = 0;
    int            mPhase    = PH_IDLE;
    int            mRelAt    = 0;
    int            mCount    = 0;
    logic [NR-1:0] mSeen     = '0;
    bit            modelLive = 0;

    logic [2:0]    expState;
    logic          expStart;
    logic          expKick;
    logic          expPeriph;
    logic          expCore;
    logic          expLock;
    logic [NR-1:0] expMissing;
    logic [3:0]    expCount;

    always @(posedge clk) begin
        logic [NR-1:0] seenN;
        int d;
        cyc++;
        expKick    = 1'b0;
        expMissing = '0;
        if (!rstn) begin
            mPhase    = PH_IDLE;
            mSeen     = '0;
            mCount    = 0;
            modelLive = 1;
        end else begin
            case (mPhase)
                PH_IDLE: begin
                    if (arm) begin
                        mPhase     = PH_ARMED;
                        mSeen      = '0;
                        expMissing = mask;
                    end
                end
                PH_ARMED: begin
                    if (wdtReset) begin
                        mCount = (mCount < 15) ? mCount + 1 : 15;
                        mPhase = (mCount >= MAXR) ? PH_LOCK : PH_HOLD;
                        mSeen  = '0;
                    end else if (!arm) begin
                        mPhase = PH_IDLE;
                        mSeen  = '0;
                    end else begin
                        seenN      = mSeen | (hb & mask);
                        expMissing = mask & ~seenN;
                        if (mask != 0 && (seenN | ~mask) == 4'hF) begin
                            expKick = 1'b1;
                            mSeen   = '0;
                        end else begin
                            mSeen = seenN & mask;
                        end
                    end
                end
                PH_HOLD: begin
                    if (!wdtReset) begin
                        mPhase = PH_SEQ;
                        mRelAt = cyc;
                    end
                end
                PH_SEQ: begin
                    if (cyc - mRelAt == PD + CD + GR) begin
                        mSeen = '0;
                        if (arm) begin
                            mPhase     = PH_ARMED;
                            expMissing = mask;
                        end else begin
                            mPhase = PH_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
        expPeriph = 1'b0;
        expCore   = 1'b0;
        expLock   = 1'b0;
        d         = cyc - mRelAt;
        case (mPhase)
            PH_IDLE:  expState = 3'd0;
            PH_ARMED: expState = 3'd1;
            PH_HOLD: begin
                expState  = 3'd2;
                expPeriph = 1'b1;
                expCore   = 1'b1;
            end
            PH_SEQ: begin
                expState  = (d < PD) ? 3'd3 : (d < PD + CD) ? 3'd4 : 3'd5;
                expPeriph = (d < PD);
                expCore   = (d < PD + CD);
            end
            default: begin
                expState  = 3'd6;
                expPeriph = 1'b1;
                expCore   = 1'b1;
                expLock   = 1'b1;
            end
        endcase
        expStart = (mPhase == PH_ARMED) && (mask != 0) && rstn;
        expCount = 4'(mCount);
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("state_o",       32'(state_o),       32'(expState));
            checkOutput("wdt_start_o",   32'(wdt_start_o),   32'(expStart));
            checkOutput("wdt_kick_o",    32'(wdt_kick_o),    32'(expKick));
            checkOutput("periph_rst_o",  32'(periph_rst_o),  32'(expPeriph));
            checkOutput("core_rst_o",    32'(core_rst_o),    32'(expCore));
            checkOutput("missing_o",     32'(missing_o),     32'(expMissing));
            checkOutput("reset_count_o", 32'(reset_count_o), 32'(expCount));
            checkOutput("lockout_o",     32'(lockout_o),     32'(expLock));
        end
    end

    initial begin
        rstn     = 1'b0;
        arm      = 1'b0;
        mask     = '0;
        hb       = '0;
        wdtReset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 0, 4'b0000, 4'b0000, 0);
        checkOutput("reset_state",  32'(state_o),       0);
        checkOutput("reset_periph", 32'(periph_rst_o),  0);
        checkOutput("reset_count",  32'(reset_count_o), 0);

        // Heartbeat window with mask 1011
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("arm_state",   32'(state_o),     1);
        checkOutput("arm_missing", 32'(missing_o),   32'h0000000b);
        checkOutput("arm_start",   32'(wdt_start_o), 1);
        applyStimulus(1, 1, 4'b1011, 4'b0001, 0);
        checkOutput("hb0_missing", 32'(missing_o), 32'h0000000a);
        applyStimulus(1, 1, 4'b1011, 4'b0100, 0);
        checkOutput("hb2_missing", 32'(missing_o), 32'h0000000a);
        checkOutput("hb2_nokick",  32'(wdt_kick_o), 0);
        applyStimulus(1, 1, 4'b1011, 4'b0010, 0);
        checkOutput("hb1_missing", 32'(missing_o), 32'h00000008);
        applyStimulus(1, 1, 4'b1011, 4'b1000, 0);
        checkOutput("hb3_kick",    32'(wdt_kick_o), 1);
        checkOutput("hb3_missing", 32'(missing_o),  0);
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("post_kick",    32'(wdt_kick_o), 0);
        checkOutput("post_missing", 32'(missing_o),  32'h0000000b);

        // Watchdog fire held for 5 cycles, then staged release
        applyStimulus(1, 1, 4'b1011, 4'b0000, 1);
        checkOutput("fire_state",  32'(state_o),       2);
        checkOutput("fire_periph", 32'(periph_rst_o),  1);
        checkOutput("fire_core",   32'(core_rst_o),    1);
        checkOutput("fire_count",  32'(reset_count_o), 1);
        checkOutput("fire_start",  32'(wdt_start_o),   0);
        repeat (4) applyStimulus(1, 1, 4'b1011, 4'b0000, 1);
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("relp_state", 32'(state_o), 3);
        repeat (3) applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("relp_hold", 32'(periph_rst_o), 1);
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("relp_done",  32'(periph_rst_o), 0);
        checkOutput("relc_state", 32'(state_o),      4);
        repeat (3) applyStimulus(1, 0, 4'b1011, 4'b1111, 0);
        checkOutput("relc_hold", 32'(core_rst_o), 1);
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("relc_done",   32'(core_rst_o), 0);
        checkOutput("grace_state", 32'(state_o),    5);
        applyStimulus(1, 1, 4'b1011, 4'b0000, 1);
        repeat (6) applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("grace_last",  32'(state_o),     5);
        checkOutput("grace_start", 32'(wdt_start_o), 0);
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("rearm_state", 32'(state_o),     1);
        checkOutput("rearm_start", 32'(wdt_start_o), 1);

        // Second fire reaches the lockout limit
        applyStimulus(1, 1, 4'b1011, 4'b0000, 1);
        checkOutput("lock_state", 32'(state_o),       6);
        checkOutput("lock_flag",  32'(lockout_o),     1);
        checkOutput("lock_count", 32'(reset_count_o), 2);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, logic'(i % 2), 4'b1111, 4'($urandom_range(0, 15)), 0);
        end
        checkOutput("lock_hold_periph", 32'(periph_rst_o), 1);
        checkOutput("lock_hold_state",  32'(state_o),      6);
        applyStimulus(0, 1, 4'b1111, 4'b0000, 0);
        checkOutput("unlock_state", 32'(state_o),       0);
        checkOutput("unlock_lock",  32'(lockout_o),     0);
        checkOutput("unlock_count", 32'(reset_count_o), 0);
        checkOutput("unlock_core",  32'(core_rst_o),    0);

        // Final heartbeat coincides with fire
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        applyStimulus(1, 1, 4'b1011, 4'b0001, 0);
        applyStimulus(1, 1, 4'b1011, 4'b0010, 0);
        applyStimulus(1, 1, 4'b1011, 4'b1000, 1);
        checkOutput("simul_kick",  32'(wdt_kick_o),    0);
        checkOutput("simul_state", 32'(state_o),       2);
        checkOutput("simul_count", 32'(reset_count_o), 1);

        // rstn in the middle of REL_CORE
        applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        repeat (5) applyStimulus(1, 1, 4'b1011, 4'b0000, 0);
        checkOutput("midcore_state", 32'(state_o),    4);
        checkOutput("midcore_core",  32'(core_rst_o), 1);
        applyStimulus(0, 1, 4'b1011, 4'b0000, 0);
        checkOutput("midrst_state", 32'(state_o),       0);
        checkOutput("midrst_core",  32'(core_rst_o),    0);
        checkOutput("midrst_count", 32'(reset_count_o), 0);

        // Empty mask: armed but timer stopped, no kicks
        applyStimulus(1, 1, 4'b0000, 4'b0000, 0);
        checkOutput("mask0_state", 32'(state_o),     1);
        checkOutput("mask0_start", 32'(wdt_start_o), 0);
        applyStimulus(1, 1, 4'b0000, 4'b1111, 0);
        checkOutput("mask0_kick", 32'(wdt_kick_o), 0);

        // Masking off a requester drops its seen bit
        applyStimulus(1, 1, 4'b0011, 4'b0001, 0);
        checkOutput("drop_a", 32'(missing_o), 32'h00000002);
        applyStimulus(1, 1, 4'b0010, 4'b0000, 0);
        checkOutput("drop_b", 32'(missing_o), 32'h00000002);
        applyStimulus(1, 1, 4'b0011, 4'b0000, 0);
        checkOutput("drop_c", 32'(missing_o), 32'h00000003);

        // Disarm mid-window
        applyStimulus(1, 1, 4'b0110, 4'b0010, 0);
        checkOutput("win_missing", 32'(missing_o), 32'h00000004);
        applyStimulus(1, 0, 4'b0110, 4'b0000, 0);
        checkOutput("disarm_state",   32'(state_o),     0);
        checkOutput("disarm_missing", 32'(missing_o),   0);
        checkOutput("disarm_start",   32'(wdt_start_o), 0);
        repeat (3) applyStimulus(1, 0, 4'b0110, 4'b0110, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/watchdog_reset_ctrl.md
Name: watchdog_reset_ctrl

Overview:
Controller for the system watchdog timer. It arms the timer and aggregates heartbeats from N requesters (cores/DMA), issuing a one-cycle kick only when every enabled requester has checked in. When the timer fires, it sequences a staged reset release (peripherals first, then cores) followed by a grace window. After MAX_RESETS watchdog resets it locks the system in reset.

Parameters:
N_REQ, 4, number of heartbeat requesters
PERIPH_DELAY, 16, cycles from timer-reset deassert to periph_rst_o release (>=1)
CORE_DELAY, 16, cycles from periph release to core_rst_o release (>=1)
GRACE_CYCLES, 1024, cycles after core release with timer disarmed (>=1)
MAX_RESETS, 3, watchdog resets before lockout (>=1)
DLY_W, 16, width of the shared delay counter; must hold max(PERIPH_DELAY, CORE_DELAY, GRACE_CYCLES)
RC_W, 4, reset_count_o width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
arm_i  in  1  level; 1 = watchdog supervision enabled
req_mask_i  in  N_REQ  per-requester enable; sampled every cycle
hb_i  in  N_REQ  heartbeat pulses, one bit per requester
wdt_reset_i  in  1  system-reset output of the watchdog timer
wdt_start_o  out  1  timer count-enable (timer start input)
wdt_kick_o  out  1  timer counter clear (timer reset input), 1-cycle pulse
periph_rst_o  out  1  active-high peripheral reset
core_rst_o  out  1  active-high core reset
missing_o  out  N_REQ  enabled requesters not yet seen in current window
reset_count_o  out  RC_W  watchdog resets since rstn, saturating
lockout_o  out  1  1 in LOCKOUT
state_o  out  3  encoded FSM state for debug

Behaviour:
- Reset (rstn=0): state IDLE; all outputs 0, seen vector 0, delay counter 0, reset_count 0. All outputs registered.
- States/encodings: IDLE=0, ARMED=1, HOLD=2, REL_PERIPH=3, REL_CORE=4, GRACE=5, LOCKOUT=6.
- IDLE: wdt_start_o=0. arm_i=1 -> ARMED next cycle, seen cleared. wdt_reset_i ignored.
- ARMED: wdt_start_o=1 iff req_mask_i!=0 (all-zero mask = nothing to watch, timer held stopped). arm_i=0 -> IDLE, wdt_start_o=0 next cycle, seen cleared.
- Heartbeat: seen_n = seen | (hb_i & req_mask_i). When req_mask_i!=0 and (seen_n | ~req_mask_i) is all ones: wdt_kick_o=1 for exactly the next cycle, seen <= 0. Heartbeats in the kicking cycle are consumed by that kick, not carried forward. Otherwise seen <= seen_n & req_mask_i (masking off a requester drops its bit).
- missing_o = req_mask_i & ~seen (registered); 0 outside ARMED.
- Fire: ARMED and wdt_reset_i=1 takes priority over kick and arm_i. Next cycle: periph_rst_o=core_rst_o=1, wdt_start_o=0, wdt_kick_o=0, reset_count+1 (saturates at 2^RC_W-1). If incremented count >= MAX_RESETS -> LOCKOUT, else HOLD.
- HOLD: wait for wdt_reset_i=0, then load delay counter, go REL_PERIPH.
- REL_PERIPH: after PERIPH_DELAY cycles in state, periph_rst_o=0, go REL_CORE.
- REL_CORE: after CORE_DELAY cycles, core_rst_o=0, go GRACE.
- GRACE: wdt_start_o=0 for GRACE_CYCLES cycles, then ARMED if arm_i=1 else IDLE; seen cleared on entry to ARMED.
- arm_i, hb_i and wdt_reset_i re-assertion are ignored in HOLD/REL_*/GRACE.
- LOCKOUT: periph_rst_o=core_rst_o=1, lockout_o=1, wdt_start_o=0; exit only via rstn.
- Delay counter: single DLY_W down-counter shared across REL_PERIPH/REL_CORE/GRACE, reloaded on every state entry. No wrap; transition on reaching 1.
- rstn mid-sequence: immediate return to reset values, including deasserting periph/core resets.

Decomposition:
- Package watchdog_pkg: state enum wdt_state_e (3-bit, encodings above) and default delay constants.
- One sub-module: hb_collector (seen vector, kick generation, missing_o), parameterised by N_REQ; FSM and delay counter stay in the top.

Test Plan:
Use N_REQ=4, PERIPH_DELAY=4, CORE_DELAY=4, GRACE_CYCLES=8, MAX_RESETS=2 throughout.
- Kick: arm_i=1, mask=4'b1011, hb bits 0,1,3 on separate cycles -> single wdt_kick_o pulse 1 cycle after bit 3; missing_o goes 1011->1010->1000->0000->1011; hb on bit 2 has no effect.
- Fire/sequence: in ARMED, wdt_reset_i=1 for 5 cycles -> both resets assert next cycle, reset_count_o=1; periph_rst_o drops 4 cycles after wdt_reset_i falls; core_rst_o drops 4 cycles later; state_o=ARMED after 8 grace cycles with wdt_start_o=1.
- Lockout: second fire -> state_o=6, lockout_o=1, resets held for 100 cycles despite wdt_reset_i=0 and arm_i toggles; rstn pulse clears everything to 0.
- Simultaneous: final heartbeat and wdt_reset_i same cycle -> no kick, HOLD entered, reset_count_o increments.
- Edge: mask=0 in ARMED -> wdt_start_o=0, no kicks; arm_i dropped mid-window -> IDLE, missing_o=0, wdt_start_o=0 next cycle.
- Reset mid-REL_CORE: rstn=0 -> next cycle all outputs 0, state_o=IDLE.
